// File: rtl/reverse_key_stream.sv
// reverse_key_stream: walks the AES-128 key schedule backwards from the
// round-10 key to the round-0 key, one round key per handshake.
// Optional feature macro: RKEY_ZEROIZE_EN clears the key register on entry
// to DONE so the recovered round-0 key is not retained.
module reverse_key_stream (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] last_round_key,
  input  logic         out_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 32;

  // Forward AES S-box; entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   key_n;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_n;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Round r key -> round r-1 key.
  function automatic logic [KEY_W-1:0] inv_step(input logic [KEY_W-1:0] k,
                                                input logic [IDX_W-1:0] r);
    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] p0, p1, p2, p3;
    logic [WORD_W-1:0] rot;
    logic [WORD_W-1:0] sub;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    p0  = w0 ^ sub ^ {rcon(r), 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  // Next-state, next key and next round index.
  always_comb begin
    state_n = state;
    key_n   = key_q;
    idx_n   = idx_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          key_n   = last_round_key;
          idx_n   = IDX_W'(10);
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q != '0) begin
            key_n = inv_step(key_q, idx_q);
            idx_n = idx_q - IDX_W'(1);
          end else begin
            state_n = DONE;
`ifdef RKEY_ZEROIZE_EN
            key_n   = '0;
`endif
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, key/index registers and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      key_q     <= '0;
      idx_q     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      key_q     <= key_n;
      idx_q     <= idx_n;
      key_valid <= (state_n == STREAM);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

  // Key and index registers are the presented outputs; the index is 0
  // outside STREAM because it only leaves STREAM after reaching 0.
  assign round_key = key_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_reverse_key_stream.sv
// Self-checking bench for reverse_key_stream; honours RKEY_ZEROIZE_EN.
module tb_reverse_key_stream;

`ifdef RKEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  localparam logic [127:0] VEC = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] last_round_key;
  logic         out_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  reverse_key_stream dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .last_round_key (last_round_key),
    .out_ready      (out_ready),
    .key_valid      (key_valid),
    .round_key      (round_key),
    .round_idx      (round_idx),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit en    = 1'b0;

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [127:0] m_keys [11];
  int           mode;     // 0 idle, 1 streaming, 2 done
  int           m_r;
  logic [127:0] m_hold;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from GF(2^8) inversion plus the affine map; Rcon by doubling.
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc[j] = xtime(rc[j-1]);
  endtask

  // Rebuild all 44 schedule words backwards from the last four.
  task automatic expand(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    w[40] = k10[127:96];
    w[41] = k10[95:64];
    w[42] = k10[63:32];
    w[43] = k10[31:0];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r < 11; r++)
      m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mode   = 0;
      m_r    = 0;
      m_hold = '0;
    end else begin
      case (mode)
        0: if (start) begin
          expand(last_round_key);
          m_r  = 10;
          mode = 1;
        end
        1: if (out_ready) begin
          if (m_r > 0) m_r = m_r - 1;
          else begin
            mode   = 2;
            m_hold = ZEROIZE ? 128'h0 : m_keys[0];
          end
        end
        default: mode = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [134:0] exp_v, act_v;
    if (en) begin
      exp_v = {mode == 1, (mode == 1) ? m_keys[m_r] : m_hold,
               (mode == 1) ? 4'(m_r) : 4'h0, mode != 0, mode == 2};
      act_v = {key_valid, round_key, round_idx, busy, done};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got v=%b k=%h i=%0d b=%b d=%b expected v=%b k=%h i=%0d b=%b d=%b",
                 $time, act_v[134], act_v[133:6], act_v[5:2], act_v[1], act_v[0],
                 exp_v[134], exp_v[133:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idx(input logic [3:0] n);
    int c;
    for (c = 0; c < 30; c++) begin
      if (key_valid && round_idx == n) break;
      tick();
    end
    if (c == 30) chk("wait_idx_timeout", 128'(round_idx), 128'(n));
  endtask

  // Start a stream from IDLE with out_ready held and check the FIPS-197 keys.
  task automatic fips_run(input string tag);
    int  nvalid = 0;
    bit  got_done = 1'b0;
    start = 1'b1; last_round_key = VEC; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (done) got_done = 1'b1;
      else begin
        if (key_valid) begin
          nvalid++;
          if (nvalid == 1) chk({tag, "_first"}, {round_key, 4'h0, round_idx}, {VEC, 4'h0, 4'd10});
          if (nvalid == 2) chk({tag, "_r9"}, {round_key, 4'h0, round_idx}, {R9, 4'h0, 4'd9});
          if (round_idx == 4'd0) chk({tag, "_r0"}, round_key, R0);
        end
        tick();
      end
    end
    chk({tag, "_done_seen"}, 128'(got_done), 128'd1);
    chk({tag, "_valid_count"}, 128'(nvalid), 128'd11);
    tick();
    chk({tag, "_post_done_valid"}, 128'(key_valid), 128'd0);
    chk({tag, "_post_done_key"}, round_key, ZEROIZE ? 128'h0 : R0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; last_round_key = '0;
    build_tables();
    chk("model_sbox_00", 128'(sb[0]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_rcon_10", 128'(rc[10]), 128'h36);
    expand(VEC);
    chk("model_r9", m_keys[9], R9);
    chk("model_r0", m_keys[0], R0);

    tick(); tick();
    en = 1'b1;
    chk("reset_outputs", {7'h0, key_valid, round_key[119:0]} | 128'(round_idx) | 128'(busy) | 128'(done),
        128'h0);
    chk("reset_key_full", round_key, 128'h0);
    reset = 1'b0;
    tick();

    fips_run("fips");

    // Backpressure at round 7 for five cycles.
    begin
      logic [127:0] held;
      start = 1'b1; last_round_key = VEC; out_ready = 1'b1;
      tick();
      start = 1'b0;
      wait_idx(4'd7);
      held = round_key;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("bp_hold", {round_key, 3'h0, key_valid, round_idx}, {held, 3'h0, 1'b1, 4'd7});
      end
      out_ready = 1'b1;
      wait_idx(4'd0);
      chk("bp_final_key", round_key, R0);
      tick();
      chk("bp_done", 128'(done), 128'd1);
      tick();
    end

    // start held high: one stream, then a fresh one only from IDLE.
    begin
      int nvalid = 0;
      int c;
      start = 1'b1; last_round_key = VEC; out_ready = 1'b1;
      tick();
      for (c = 0; c < 20; c++) begin
        if (done) break;
        if (key_valid) nvalid++;
        tick();
      end
      chk("held_start_valid_count", 128'(nvalid), 128'd11);
      tick();
      chk("held_start_ignored_in_done", {126'h0, key_valid, busy}, 128'h0);
      tick();
      chk("held_start_restart", {123'h0, key_valid, round_idx}, {123'h0, 1'b1, 4'd10});
      start = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    // Reset mid-stream at round 4, then replay the vector.
    start = 1'b1; last_round_key = VEC; out_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(4'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_outputs", {round_key ^ 128'(round_idx)}, 128'h0);
    chk("midreset_flags", {125'h0, key_valid, busy, done}, 128'h0);
    fips_run("replay");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start          = ($urandom_range(0, 3) == 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      reset          = ($urandom_range(0, 150) == 0);
      last_round_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    reset = 1'b1; start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
